// File: rtl/rvfi_check_pkg.sv
// Shared definitions for the RVFI data-memory window checker: checker state
// encoding and error-counter width.
`timescale 1ns/1ps
package rvfi_check_pkg;
  localparam int COUNT_W = 16;

  typedef enum logic {
    CHECK = 1'b0,
    FAIL  = 1'b1
  } chk_state_e;
endpackage

// File: rtl/rvfi_dmem_window_check_if.sv
// RVFI memory-retire bundle, one slice of each field per retire channel.
`timescale 1ns/1ps
interface rvfi_dmem_window_check_if #(
  parameter int XLEN = 32,
  parameter int NRET = 1
);
  logic [NRET-1:0]          rvfi_valid;
  logic [NRET*64-1:0]       rvfi_order;
  logic [NRET*XLEN-1:0]     rvfi_mem_addr;
  logic [NRET*XLEN/8-1:0]   rvfi_mem_rmask;
  logic [NRET*XLEN/8-1:0]   rvfi_mem_wmask;
  logic [NRET*XLEN-1:0]     rvfi_mem_rdata;
  logic [NRET*XLEN-1:0]     rvfi_mem_wdata;

  modport master (
    output rvfi_valid, rvfi_order, rvfi_mem_addr, rvfi_mem_rmask,
           rvfi_mem_wmask, rvfi_mem_rdata, rvfi_mem_wdata
  );
  modport slave (
    input  rvfi_valid, rvfi_order, rvfi_mem_addr, rvfi_mem_rmask,
           rvfi_mem_wmask, rvfi_mem_rdata, rvfi_mem_wdata
  );
endinterface

// File: rtl/rvfi_dmem_shadow_word.sv
// One shadowed memory word: XLEN/8 data bytes plus a written bit per byte.
`timescale 1ns/1ps
module rvfi_dmem_shadow_word #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              upd,
  input  logic [XLEN/8-1:0] wr_next,
  input  logic [XLEN-1:0]   data_next,
  output logic [XLEN/8-1:0] written,
  output logic [XLEN-1:0]   data
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    written <= '0;
    else if (upd) written <= wr_next;
  end

  // Data bytes carry no reset; they are only trusted once their written bit is set.
  always_ff @(posedge clk) begin
    if (upd) data <= data_next;
  end
endmodule

// File: rtl/rvfi_dmem_window_check.sv
// Shadows a small window of data memory from RVFI retires and flags any read
// whose data disagrees with previously retired writes.
`timescale 1ns/1ps
module rvfi_dmem_window_check
  import rvfi_check_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int NRET        = 1,
  parameter int NWORDS      = 4,
  parameter bit STOP_ON_ERR = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [XLEN-1:0]         dmem_base,
  rvfi_dmem_window_check_if.slave rvfi,
  output logic                    err,
  output logic [COUNT_W-1:0]      err_count,
  output logic [63:0]             err_order,
  output logic [1:0]              err_chan,
  output logic [XLEN-1:0]         err_addr,
  output logic [XLEN/8-1:0]       err_lanes
);
  localparam int NB = XLEN / 8;

  logic [NB-1:0]   sh_wr   [NWORDS];
  logic [XLEN-1:0] sh_data [NWORDS];
  logic [NB-1:0]   nx_wr   [NWORDS];
  logic [XLEN-1:0] nx_data [NWORDS];
  logic [NB-1:0]   mis_p0  [NRET];
  logic [XLEN-1:0] waddr   [NRET];

  logic            any_mis;
  logic [7:0]      lane_sum;
  logic [1:0]      cap_chan;
  logic [63:0]     cap_order;
  logic [XLEN-1:0] cap_addr;
  logic [NB-1:0]   cap_lanes;
  logic            upd;
  chk_state_e      state_q, state_d;

  function automatic logic [COUNT_W-1:0] sat_add(input logic [COUNT_W-1:0] a,
                                                 input logic [7:0] b);
    logic [COUNT_W:0] s;
    s = {1'b0, a} + (COUNT_W+1)'(b);
    return s[COUNT_W] ? {COUNT_W{1'b1}} : s[COUNT_W-1:0];
  endfunction

  // Stage p0: channels walk a working copy of the shadow in ascending order,
  // so a higher channel reads what lower channels wrote this same cycle.
  always_comb begin
    nx_wr   = sh_wr;
    nx_data = sh_data;
    for (int c = 0; c < NRET; c++) begin
      waddr[c]  = rvfi.rvfi_mem_addr[c*XLEN +: XLEN] & ~XLEN'(NB-1);
      mis_p0[c] = '0;
      for (int k = 0; k < NWORDS; k++) begin
        if (rvfi.rvfi_valid[c] && (waddr[c] == dmem_base + XLEN'(k*NB))) begin
          for (int i = 0; i < NB; i++) begin
            if (rvfi.rvfi_mem_rmask[c*NB+i] && nx_wr[k][i] &&
                (nx_data[k][i*8 +: 8] != rvfi.rvfi_mem_rdata[c*XLEN + i*8 +: 8]))
              mis_p0[c][i] = 1'b1;
          end
          for (int i = 0; i < NB; i++) begin
            if (rvfi.rvfi_mem_wmask[c*NB+i]) begin
              nx_data[k][i*8 +: 8] = rvfi.rvfi_mem_wdata[c*XLEN + i*8 +: 8];
              nx_wr[k][i]          = 1'b1;
            end
          end
        end
      end
    end
  end

  // Descending walk leaves the lowest failing channel in the capture fields.
  always_comb begin
    any_mis   = 1'b0;
    lane_sum  = '0;
    cap_chan  = '0;
    cap_order = '0;
    cap_addr  = '0;
    cap_lanes = '0;
    for (int c = NRET-1; c >= 0; c--) begin
      if (|mis_p0[c]) begin
        any_mis   = 1'b1;
        cap_chan  = 2'(c);
        cap_order = rvfi.rvfi_order[c*64 +: 64];
        cap_addr  = waddr[c];
        cap_lanes = mis_p0[c];
      end
      for (int i = 0; i < NB; i++) lane_sum = lane_sum + 8'(mis_p0[c][i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= CHECK;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == CHECK && any_mis) state_d = FAIL;
  end

  assign err = (state_q == FAIL);
  assign upd = !(STOP_ON_ERR && state_q == FAIL);

  for (genvar k = 0; k < NWORDS; k++) begin : g_word
    rvfi_dmem_shadow_word #(.XLEN(XLEN)) u_word (
      .clk       (clk),
      .reset     (reset),
      .upd       (upd),
      .wr_next   (nx_wr[k]),
      .data_next (nx_data[k]),
      .written   (sh_wr[k]),
      .data      (sh_data[k])
    );
  end

  // Stage p1: registered error report.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= '0;
      err_order <= '0;
      err_chan  <= '0;
      err_addr  <= '0;
      err_lanes <= '0;
    end else begin
      if (upd) err_count <= sat_add(err_count, lane_sum);
      if (state_q == CHECK && any_mis) begin
        err_order <= cap_order;
        err_chan  <= cap_chan;
        err_addr  <= cap_addr;
        err_lanes <= cap_lanes;
      end
    end
  end
endmodule

// File: tb/tb_rvfi_dmem_window_check.sv
// Directed bench for rvfi_dmem_window_check: two retire channels, one checker
// that freezes on error and one that keeps counting.
`timescale 1ns/1ps
module tb_rvfi_dmem_window_check;
  typedef struct {
    string       name;
    logic [1:0]  v;
    logic [31:0] a0, a1;
    logic [3:0]  r0, w0, r1, w1;
    logic [31:0] rd0, wd0, rd1, wd1;
    logic [63:0] ord;
    logic        e_err;
    logic [15:0] e_cnt;
    logic [1:0]  e_chan;
    logic [63:0] e_ord;
    logic [31:0] e_addr;
    logic [3:0]  e_lanes;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dmem_base = 32'h1000;

  logic        err_a, err_b;
  logic [15:0] cnt_a, cnt_b;
  logic [63:0] ord_a, ord_b;
  logic [1:0]  chan_a, chan_b;
  logic [31:0] addr_a, addr_b;
  logic [3:0]  lanes_a, lanes_b;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  rvfi_dmem_window_check_if #(.XLEN(32), .NRET(2)) rvfi ();

  rvfi_dmem_window_check #(.XLEN(32), .NRET(2), .NWORDS(4), .STOP_ON_ERR(1'b1)) dut (
    .clk(clk), .reset(reset), .dmem_base(dmem_base), .rvfi(rvfi),
    .err(err_a), .err_count(cnt_a), .err_order(ord_a), .err_chan(chan_a),
    .err_addr(addr_a), .err_lanes(lanes_a)
  );

  rvfi_dmem_window_check #(.XLEN(32), .NRET(2), .NWORDS(4), .STOP_ON_ERR(1'b0)) dut_run (
    .clk(clk), .reset(reset), .dmem_base(dmem_base), .rvfi(rvfi),
    .err(err_b), .err_count(cnt_b), .err_order(ord_b), .err_chan(chan_b),
    .err_addr(addr_b), .err_lanes(lanes_b)
  );

  function automatic vec_t mk(string name, logic [1:0] v,
      logic [31:0] a0, logic [3:0] r0, logic [3:0] w0, logic [31:0] rd0, logic [31:0] wd0,
      logic [31:0] a1, logic [3:0] r1, logic [3:0] w1, logic [31:0] rd1, logic [31:0] wd1,
      logic [63:0] ord, logic e_err, logic [15:0] e_cnt, logic [1:0] e_chan,
      logic [63:0] e_ord, logic [31:0] e_addr, logic [3:0] e_lanes);
    vec_t t;
    t.name = name; t.v = v; t.a0 = a0; t.r0 = r0; t.w0 = w0; t.rd0 = rd0; t.wd0 = wd0;
    t.a1 = a1; t.r1 = r1; t.w1 = w1; t.rd1 = rd1; t.wd1 = wd1; t.ord = ord;
    t.e_err = e_err; t.e_cnt = e_cnt; t.e_chan = e_chan; t.e_ord = e_ord;
    t.e_addr = e_addr; t.e_lanes = e_lanes;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    rvfi.rvfi_valid     = t.v;
    rvfi.rvfi_order     = {t.ord + 64'd1, t.ord};
    rvfi.rvfi_mem_addr  = {t.a1, t.a0};
    rvfi.rvfi_mem_rmask = {t.r1, t.r0};
    rvfi.rvfi_mem_wmask = {t.w1, t.w0};
    rvfi.rvfi_mem_rdata = {t.rd1, t.rd0};
    rvfi.rvfi_mem_wdata = {t.wd1, t.wd0};
  endtask

  task automatic idle();
    rvfi.rvfi_valid     = '0;
    rvfi.rvfi_order     = '0;
    rvfi.rvfi_mem_addr  = '0;
    rvfi.rvfi_mem_rmask = '0;
    rvfi.rvfi_mem_wmask = '0;
    rvfi.rvfi_mem_rdata = '0;
    rvfi.rvfi_mem_wdata = '0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_a(input string nm, input logic e, input logic [15:0] c, input logic [1:0] ch,
                       input logic [63:0] o, input logic [31:0] ad, input logic [3:0] ln);
    chk({nm, ".err"},   64'(err_a),   64'(e));
    chk({nm, ".count"}, 64'(cnt_a),   64'(c));
    chk({nm, ".chan"},  64'(chan_a),  64'(ch));
    chk({nm, ".order"}, ord_a,        o);
    chk({nm, ".addr"},  64'(addr_a),  64'(ad));
    chk({nm, ".lanes"}, 64'(lanes_a), 64'(ln));
  endtask

  task automatic chk_b(input string nm, input logic e, input logic [15:0] c, input logic [1:0] ch,
                       input logic [63:0] o, input logic [31:0] ad, input logic [3:0] ln);
    chk({nm, ".b_err"},   64'(err_b),   64'(e));
    chk({nm, ".b_count"}, 64'(cnt_b),   64'(c));
    chk({nm, ".b_chan"},  64'(chan_b),  64'(ch));
    chk({nm, ".b_order"}, ord_b,        o);
    chk({nm, ".b_addr"},  64'(addr_b),  64'(ad));
    chk({nm, ".b_lanes"}, 64'(lanes_b), 64'(ln));
  endtask

  initial begin
    tbl.push_back(mk("sw_1004",        2'b01, 32'h1004, 4'h0, 4'hF, 32'h0, 32'hDEADBEEF, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 64'd0, 0, 16'd0, 2'd0, 64'd0, 32'h0, 4'h0));
    tbl.push_back(mk("lw_1004_ok",     2'b01, 32'h1004, 4'hF, 4'h0, 32'hDEADBEEF, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 64'd1, 0, 16'd0, 2'd0, 64'd0, 32'h0, 4'h0));
    tbl.push_back(mk("sb_lb_fwd",      2'b11, 32'h1008, 4'h0, 4'h1, 32'h0, 32'h00000055, 32'h1008, 4'h1, 4'h0, 32'h00000055, 32'h0, 64'd2, 0, 16'd0, 2'd0, 64'd0, 32'h0, 4'h0));
    tbl.push_back(mk("lw_100c_unwr",   2'b01, 32'h100C, 4'hF, 4'h0, 32'h12345678, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 64'd3, 0, 16'd0, 2'd0, 64'd0, 32'h0, 4'h0));
    tbl.push_back(mk("same_byte_wins", 2'b11, 32'h1000, 4'h0, 4'hF, 32'h0, 32'h11111111, 32'h1000, 4'h0, 4'hF, 32'h0, 32'h22222222, 64'd4, 0, 16'd0, 2'd0, 64'd0, 32'h0, 4'h0));
    tbl.push_back(mk("lw_1000_ch1won", 2'b01, 32'h1000, 4'hF, 4'h0, 32'h22222222, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 64'd5, 0, 16'd0, 2'd0, 64'd0, 32'h0, 4'h0));
    tbl.push_back(mk("sw_1010_out",    2'b01, 32'h1010, 4'h0, 4'hF, 32'h0, 32'h00000000, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 64'd6, 0, 16'd0, 2'd0, 64'd0, 32'h0, 4'h0));
    tbl.push_back(mk("lw_1000_noalias",2'b01, 32'h1000, 4'hF, 4'h0, 32'h22222222, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 64'd7, 0, 16'd0, 2'd0, 64'd0, 32'h0, 4'h0));
    tbl.push_back(mk("lw_1010_out",    2'b01, 32'h1010, 4'hF, 4'h0, 32'hFFFFFFFF, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 64'd8, 0, 16'd0, 2'd0, 64'd0, 32'h0, 4'h0));
    tbl.push_back(mk("sw_100c",        2'b01, 32'h100C, 4'h0, 4'hF, 32'h0, 32'hAABBCCDD, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 64'd9, 0, 16'd0, 2'd0, 64'd0, 32'h0, 4'h0));
    tbl.push_back(mk("rd_before_wr",   2'b11, 32'h100C, 4'hF, 4'h0, 32'hAABBCCDD, 32'h0, 32'h100C, 4'h0, 4'hF, 32'h0, 32'h00000000, 64'd10, 0, 16'd0, 2'd0, 64'd0, 32'h0, 4'h0));
    tbl.push_back(mk("lw_new_lb_lane2",2'b11, 32'h100C, 4'hF, 4'h0, 32'h00000000, 32'h0, 32'h1006, 4'h4, 4'h0, 32'h00AD0000, 32'h0, 64'd12, 0, 16'd0, 2'd0, 64'd0, 32'h0, 4'h0));
    tbl.push_back(mk("lw_1004_bad",    2'b01, 32'h1004, 4'hF, 4'h0, 32'hDEADBEEE, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 64'd7, 1, 16'd1, 2'd0, 64'd7, 32'h1004, 4'h1));
    tbl.push_back(mk("frozen",         2'b11, 32'h1004, 4'hF, 4'h0, 32'h00000000, 32'h0, 32'h1008, 4'h1, 4'h0, 32'h0, 32'h0, 64'd20, 1, 16'd1, 2'd0, 64'd7, 32'h1004, 4'h1));

    idle();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_a("reset", 1'b0, 16'd0, 2'd0, 64'd0, 32'h0, 4'h0);
    reset = 1'b0;

    foreach (tbl[n]) begin
      drive(tbl[n]);
      step();
      chk_a(tbl[n].name, tbl[n].e_err, tbl[n].e_cnt, tbl[n].e_chan, tbl[n].e_ord, tbl[n].e_addr, tbl[n].e_lanes);
    end
    // Non-freezing checker: 1 lane at the first failure, then 4 + 1 more.
    chk_b("run_after_fail", 1'b1, 16'd6, 2'd0, 64'd7, 32'h1004, 4'h1);

    // 8750 cycles x 2 channels x 4 lanes = 70000 mismatching lanes.
    drive(mk("sat", 2'b11, 32'h1004, 4'hF, 4'h0, 32'h21524110, 32'h0, 32'h1004, 4'hF, 4'h0, 32'h21524110, 32'h0, 64'd30, 0, 16'd0, 2'd0, 64'd0, 32'h0, 4'h0));
    repeat (8750) step();
    chk_a("stop_frozen", 1'b1, 16'd1, 2'd0, 64'd7, 32'h1004, 4'h1);
    chk_b("saturated", 1'b1, 16'hFFFF, 2'd0, 64'd7, 32'h1004, 4'h1);

    // Asynchronous reset in mid-cycle while a mismatching retire is presented.
    #2 reset = 1'b1;
    #1;
    chk_a("async_reset", 1'b0, 16'd0, 2'd0, 64'd0, 32'h0, 4'h0);
    chk_b("async_reset", 1'b0, 16'd0, 2'd0, 64'd0, 32'h0, 4'h0);
    step();
    reset = 1'b0;
    idle();
    step();
    chk_a("post_reset_idle", 1'b0, 16'd0, 2'd0, 64'd0, 32'h0, 4'h0);

    drive(mk("stale", 2'b01, 32'h1004, 4'hF, 4'h0, 32'h00000000, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 64'd40, 0, 16'd0, 2'd0, 64'd0, 32'h0, 4'h0));
    step();
    chk_a("stale_shadow", 1'b0, 16'd0, 2'd0, 64'd0, 32'h0, 4'h0);
    chk_b("stale_shadow", 1'b0, 16'd0, 2'd0, 64'd0, 32'h0, 4'h0);

    // Forwarded byte mismatching on channel 1 (ch1 order = 8 + 1).
    drive(mk("fwd_bad", 2'b11, 32'h1008, 4'h0, 4'h1, 32'h0, 32'h00000055, 32'h1008, 4'h1, 4'h0, 32'h00000000, 32'h0, 64'd8, 0, 16'd0, 2'd0, 64'd0, 32'h0, 4'h0));
    step();
    idle();
    chk_a("fwd_bad_ch1", 1'b1, 16'd1, 2'd1, 64'd9, 32'h1008, 4'h1);
    chk_b("fwd_bad_ch1", 1'b1, 16'd1, 2'd1, 64'd9, 32'h1008, 4'h1);

    // Both channels fail in one cycle: lowest channel captured, all lanes counted.
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(mk("wr2", 2'b01, 32'h100C, 4'h0, 4'hF, 32'h0, 32'hAABBCCDD, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 64'd50, 0, 16'd0, 2'd0, 64'd0, 32'h0, 4'h0));
    step();
    drive(mk("two_fail", 2'b11, 32'h100C, 4'hF, 4'h0, 32'hAABBCC00, 32'h0, 32'h100C, 4'hF, 4'h0, 32'h00BBCCDD, 32'h0, 64'd60, 0, 16'd0, 2'd0, 64'd0, 32'h0, 4'h0));
    step();
    idle();
    chk_a("two_chan_fail", 1'b1, 16'd2, 2'd0, 64'd60, 32'h100C, 4'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rvfi_dmem_window_check.md
RVFI_DMEM_WINDOW_CHECK -- requirements
Module: rvfi_dmem_window_check

Interface
REQ-001 Param XLEN, default 32, datapath width; legal 32 or 64.
REQ-002 Param NRET, default 1, retire channels; legal 1..4.
REQ-003 Param NWORDS, default 4, shadowed consecutive words; power of two, 1..16.
REQ-004 Param STOP_ON_ERR, default 1; 1 freezes checking after first mismatch.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 dmem_base  in  XLEN  window base, NWORDS*XLEN/8-aligned, stable while reset low.
REQ-008 rvfi_valid  in  NRET  per-channel retire strobe.
REQ-009 rvfi_order  in  NRET*64  per-channel retire order.
REQ-010 rvfi_mem_addr  in  NRET*XLEN  per-channel access address (word-aligned).
REQ-011 rvfi_mem_rmask / rvfi_mem_wmask  in  NRET*XLEN/8 each  byte read/write masks.
REQ-012 rvfi_mem_rdata / rvfi_mem_wdata  in  NRET*XLEN each  read/write data.
REQ-013 err  out  1  sticky mismatch flag.
REQ-014 err_count  out  16  saturating mismatched-byte-lane count.
REQ-015 err_order  out  64  rvfi_order of first failing retire.
REQ-016 err_chan  out  2  channel of first failure.
REQ-017 err_addr  out  XLEN  word address of first failure.
REQ-018 err_lanes  out  XLEN/8  mismatching byte lanes of first failure.

Function
REQ-019 Access hits word k when rvfi_mem_addr[ch] with low log2(XLEN/8) bits cleared equals dmem_base + k*XLEN/8, k<NWORDS.
REQ-020 Shadow holds NWORDS*XLEN/8 bytes, each with written bit; written bits clear on reset.
REQ-021 Per hit, lane i with rmask[i] and written set mismatches when shadow byte != that channel's rdata byte i; unwritten lanes never mismatch.
REQ-022 Lanes with wmask[i] update shadow byte from that channel's wdata and set written, after that channel's read compare.
REQ-023 Channels processed ascending within a cycle; a higher channel's read sees lower channels' same-cycle writes (combinational forwarding).
REQ-024 Same-cycle writes to same byte from several channels: highest channel wins.
REQ-025 State machine CHECK -> FAIL on any mismatch; FAIL -> CHECK only via reset.
REQ-026 In CHECK, mismatch cycle: err=1 next cycle; capture fields latch lowest failing channel's data next cycle.
REQ-027 err_count increments by total mismatching lanes across all channels that cycle, saturating at 16'hFFFF.
REQ-028 STOP_ON_ERR=1: in FAIL, shadow, written bits, err_count frozen; STOP_ON_ERR=0: shadow/counter keep updating, capture fields hold first failure.
REQ-029 Latency: mismatch at edge N visible on outputs after edge N+1 (one register stage).
REQ-030 Non-hitting or rvfi_valid=0 channels have no effect.

Reset
REQ-031 Reset asserted: state=CHECK, err=0, err_count=0, err_order=0, err_chan=0, err_addr=0, err_lanes=0, all written bits 0; shadow data undefined.
REQ-032 Reset mid-cycle overrides all same-cycle retire activity; checking resumes first edge after deassertion.

Structure
REQ-033 State encoding (CHECK, FAIL) and COUNT_W=16 live in shared package rvfi_check_pkg.
REQ-034 One sub-module rvfi_dmem_shadow_word per word: holds XLEN/8 bytes plus written bits, instantiated NWORDS times.

Verification
REQ-035 XLEN=32, base=0x1000: ch0 SW 0xDEADBEEF @0x1004, later LW @0x1004 rdata 0xDEADBEEF -> err=0, err_count=0.
REQ-036 After REQ-035, LW @0x1004 rdata 0xDEADBEEE, order 7 -> err=1 next cycle, err_count=1, err_order=7, err_addr=0x1004, err_lanes=4'b0001.
REQ-037 NRET=2 same cycle: ch0 SB 0x55 @0x1008 lane0, ch1 LB @0x1008 rdata 0x55 -> no error; rdata 0x00 -> err_chan=1.
REQ-038 LW @0x100C before any write, arbitrary rdata -> err=0; access @0x1010 (outside NWORDS=4) -> ignored.
REQ-039 STOP_ON_ERR=1 after failure: 70000 further mismatching lanes -> err_count stays 1; STOP_ON_ERR=0 -> saturates at 0xFFFF.
REQ-040 Reset pulsed mid-run with err=1 -> all outputs 0, written bits cleared, prior shadow data no longer compared.
